// File: rtl/adc_spi_responder.sv
// Emulated 10-bit serial ADC: shifts one queued sample per CS-low frame on the
// initiator's SPI_clk, fed from a one-entry valid/ready holding register.
module adc_spi_responder #(
    parameter int unsigned DATA_WIDTH  = 10,
    parameter int unsigned LEAD_ZEROS  = 3,
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  SPI_clk,
    input  logic                  CS,
    output logic                  SPI_Data_out,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  frame_done,
    output logic                  frame_abort,
    output logic                  underrun
);

    localparam int unsigned CntW  = $clog2(FRAME_BITS + 1);
    localparam int unsigned FillW = FRAME_BITS - LEAD_ZEROS - DATA_WIDTH;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic                   sclk_fall_q, cs_fall_q, cs_rise_q;

    state_e                 state_q, state_d;
    logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic [CntW-1:0]        bitcnt_q, bitcnt_d;
    logic [DATA_WIDTH-1:0]  hold_data_q, hold_data_d;
    logic                   hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0]  last_q, last_d;
    logic                   done_q, done_d, abort_q, abort_d, underrun_q, underrun_d;
    logic                   consume, transfer;
    logic [DATA_WIDTH-1:0]  sel_sample;

    // Synchronizers reset to the idle-high levels so a CS already low at
    // reset release is seen as a fresh falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '1;
            cs_sync_q   <= '1;
            sclk_prev_q <= 1'b1;
            cs_prev_q   <= 1'b1;
            sclk_fall_q <= 1'b0;
            cs_fall_q   <= 1'b0;
            cs_rise_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], CS};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
            sclk_fall_q <= sclk_prev_q & ~sclk_sync_q[SYNC_STAGES-1];
            cs_fall_q   <= cs_prev_q & ~cs_sync_q[SYNC_STAGES-1];
            cs_rise_q   <= ~cs_prev_q & cs_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            hold_data_q <= '0;
            hold_full_q <= 1'b0;
            last_q      <= '0;
            done_q      <= 1'b0;
            abort_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            last_q      <= last_d;
            done_q      <= done_d;
            abort_q     <= abort_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        last_d      = last_q;
        done_d      = 1'b0;
        abort_d     = 1'b0;
        underrun_d  = 1'b0;
        consume     = 1'b0;
        sel_sample  = hold_full_q ? hold_data_q : last_q;

        unique case (state_q)
            StIdle: begin
                if (cs_fall_q) begin
                    consume    = 1'b1;
                    shreg_d    = FRAME_BITS'(sel_sample) << FillW;
                    underrun_d = ~hold_full_q;
                    last_d     = sel_sample;
                    bitcnt_d   = '0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                // cs_rise beats a same-cycle sclk_fall; the shift is dropped.
                if (cs_rise_q) begin
                    abort_d = 1'b1;
                    state_d = StIdle;
                end else if (sclk_fall_q) begin
                    shreg_d = shreg_q << 1;
                    if (bitcnt_q != CntW'(FRAME_BITS)) bitcnt_d = bitcnt_q + CntW'(1);
                    if (bitcnt_q == CntW'(FRAME_BITS - 1)) state_d = StDone;
                end
            end
            StDone: begin
                if (cs_rise_q) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        sample_ready = ~hold_full_q | consume;
        transfer     = sample_valid & sample_ready;
        if (transfer) begin
            hold_data_d = sample_in;
            hold_full_d = 1'b1;
        end else if (consume) begin
            hold_full_d = 1'b0;
        end
    end

    assign SPI_Data_out = (state_q == StShift) ? shreg_q[FRAME_BITS-1] : 1'b0;
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized self-checking bench: an SPI initiator drives frames and the captured
// bits and event pulses are compared against a frame-level model of the ADC.
module tb_adc_spi_responder;

    localparam int FRAME = 16;
    localparam int LZ    = 3;
    localparam int DW    = 10;
    localparam int HALF  = 7;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          SPI_clk = 1'b1;
    logic          CS = 1'b1;
    logic          SPI_Data_out;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid = 1'b0;
    logic          sample_ready, frame_done, frame_abort, underrun;

    adc_spi_responder dut (
        .clk          (clk),
        .reset        (reset),
        .SPI_clk      (SPI_clk),
        .CS           (CS),
        .SPI_Data_out (SPI_Data_out),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_done = 0, n_abort = 0, n_ur = 0;
    logic cap [0:31];

    // Reference model: one-entry holding register plus last framed sample.
    logic          m_full = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [DW-1:0] m_last = '0;

    always @(negedge clk) begin
        if (frame_done)  n_done  <= n_done + 1;
        if (frame_abort) n_abort <= n_abort + 1;
        if (underrun)    n_ur    <= n_ur + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [DW-1:0] s, input int k);
        if (k >= LZ && k < LZ + DW) return s[DW-1-(k-LZ)];
        return 1'b0;
    endfunction

    task automatic push(input logic [DW-1:0] d);
        bit ok = 0;
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = d;
        for (int i = 0; i < 2000; i++) begin
            if (sample_ready) begin
                @(posedge clk);
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("push_accept", 32'(ok), 1);
        if (ok) begin
            m_full = 1'b1;
            m_data = d;
        end
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Initiator samples just before each falling edge, so capture k is frame bit k.
    task automatic run_falls(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (HALF) @(negedge clk);
            cap[k]  = SPI_Data_out;
            SPI_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            SPI_clk = 1'b1;
        end
    endtask

    task automatic check_frame(input string tag, input int n, input logic [DW-1:0] s,
                               input bit exp_ur, input int bd, input int ba, input int bu);
        for (int k = 0; k < n; k++)
            chk($sformatf("%s_bit%0d", tag, k), 32'(cap[k]), 32'(exp_bit(s, k)));
        chk({tag, "_done"}, n_done - bd, (n >= FRAME) ? 1 : 0);
        chk({tag, "_abort"}, n_abort - ba, (n < FRAME) ? 1 : 0);
        chk({tag, "_underrun"}, n_ur - bu, exp_ur ? 1 : 0);
        chk({tag, "_idle_out"}, 32'(SPI_Data_out), 0);
    endtask

    task automatic frame(input string tag, input int n);
        logic [DW-1:0] s;
        bit            ur;
        int            bd, ba, bu;
        s  = m_full ? m_data : m_last;
        ur = !m_full;
        m_last = s;
        m_full = 1'b0;
        bd = n_done; ba = n_abort; bu = n_ur;
        CS = 1'b0;
        run_falls(n);
        repeat (HALF) @(negedge clk);
        CS = 1'b1;
        repeat (10) @(negedge clk);
        check_frame(tag, n, s, ur, bd, ba, bu);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] word;
        logic [DW-1:0] s;
        int bd, ba, bu, n;

        repeat (4) @(negedge clk);
        chk("rst_data", 32'(SPI_Data_out), 0);
        chk("rst_ready", 32'(sample_ready), 1);
        chk("rst_done", 32'(frame_done), 0);
        chk("rst_abort", 32'(frame_abort), 0);
        chk("rst_underrun", 32'(underrun), 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        push(10'h2A5);
        frame("single", 16);
        for (int k = 0; k < 16; k++) word[15-k] = cap[k];
        chk("single_word", 32'(word), 32'h1528);

        frame("underrun", 16);

        push(10'h3FF);
        frame("abort", 7);
        push(10'h001);
        frame("after_abort", 16);

        push(10'h100);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = 10'h200;
        repeat (5) @(negedge clk);
        chk("bp_ready_low", 32'(sample_ready), 0);
        fork
            frame("bp_first", 16);
            push(10'h200);
        join
        frame("bp_second", 16);

        push(10'h155);
        s = m_full ? m_data : m_last;
        m_last = s;
        m_full = 1'b0;
        CS = 1'b0;
        run_falls(5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_data", 32'(SPI_Data_out), 0);
        chk("rstmid_ready", 32'(sample_ready), 1);
        chk("rstmid_done", 32'(frame_done), 0);
        chk("rstmid_abort", 32'(frame_abort), 0);
        chk("rstmid_underrun", 32'(underrun), 0);
        m_full = 1'b0;
        m_last = '0;
        bd = n_done; ba = n_abort; bu = n_ur;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_falls(16);
        repeat (HALF) @(negedge clk);
        CS = 1'b1;
        repeat (10) @(negedge clk);
        check_frame("rstmid", 16, '0, 1'b1, bd, ba, bu);
        m_last = '0;

        push(DW'($urandom_range(1023, 0)));
        frame("extra", 20);

        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(1, 0) == 1) push(DW'($urandom_range(1023, 0)));
            case ($urandom_range(2, 0))
                0:       n = 16;
                1:       n = int'($urandom_range(15, 1));
                default: n = int'($urandom_range(20, 17));
            endcase
            frame($sformatf("rnd%0d", i), n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
